// File: rtl/ultrasonic_pkg.sv
// ultrasonic_pkg: shared definitions for the two-channel ultrasonic ranger.
// Holds the FSM state encoding, channel encoding, default timing constants
// for a 3.125 MHz clock, datapath widths and the echo-count-to-millimetre
// scaling function.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    GAP       = 3'd4
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  // Defaults at 3.125 MHz (320 ns per clock).
  localparam int DEF_TRIG_CYCLES    = 32;      // 10.24 us trigger pulse
  localparam int DEF_TIMEOUT_CYCLES = 118750;  // 38 ms echo window
  localparam int DEF_GAP_CYCLES     = 6250;    // 2 ms between channels
  localparam int DEF_SCALE          = 3597;    // 0.05488 mm/clk in Q0.16

  localparam logic [15:0] TIMEOUT_DIST = 16'hFFFF;

  localparam int CNT_W   = 17;               // echo high-time counter
  localparam int SCALE_W = 12;               // Q0.16 scale factor
  localparam int PROD_W  = CNT_W + SCALE_W;  // 29-bit product

  // Echo clocks to millimetres: (count * scale) >> 16, truncated.
  // Worst case at the timeout bound is ~6517 mm, so 16 bits never overflow.
  function automatic logic [15:0] scale_dist(input logic [CNT_W-1:0]   count,
                                             input logic [SCALE_W-1:0] scale);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(count) * PROD_W'(scale);
    return 16'(prod >> 16);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// echo_sync: two-flop synchronizer for one asynchronous echo input, plus
// single-cycle edge pulses derived from the synchronized level.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   i_echo   in   asynchronous echo from the sensor
//   o_level  out  synchronized echo level (two clocks behind i_echo)
//   o_rise   out  one-cycle pulse when o_level goes 0 -> 1
//   o_fall   out  one-cycle pulse when o_level goes 1 -> 0
module echo_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_echo,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger: alternately triggers a left and a right ultrasonic
// sensor, times the returned echo pulse and converts it to millimetres.
// Ports:
//   clk_3125KHz  in   system clock, 3.125 MHz
//   reset        in   synchronous, active-high
//   echo_left    in   asynchronous echo, left sensor
//   echo_right   in   asynchronous echo, right sensor
//   trig_left    out  trigger, left sensor
//   trig_right   out  trigger, right sensor
//   dist_left    out  left distance in mm (16'hFFFF = no echo)
//   dist_right   out  right distance in mm (16'hFFFF = no echo)
//   dist_valid   out  one-cycle pulse when a dist output was updated
//   dist_ch      out  channel of the last update, 0 = left, 1 = right
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | one cycle; arm the trigger for the selected channel
// TRIG      | selected trigger high for TRIG_CYCLES clocks
// WAIT_ECHO | wait for a synchronized rising echo edge; timeout running
// MEASURE   | count echo-high clocks until the falling edge or timeout
// GAP       | GAP_CYCLES quiet time, echoes ignored, then swap channel
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int SCALE          = DEF_SCALE
) (
  input  logic        clk_3125KHz,
  input  logic        reset,
  input  logic        echo_left,
  input  logic        echo_right,
  output logic        trig_left,
  output logic        trig_right,
  output logic [15:0] dist_left,
  output logic [15:0] dist_right,
  output logic        dist_valid,
  output logic        dist_ch
);

  localparam int TIMER_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TRIG_LOAD = TIMER_W'(TRIG_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LOAD  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SCALE_W-1:0] SCALE_Q   = SCALE_W'(SCALE);

  state_t             r_state;
  logic               r_ch;
  logic               r_trig_l;
  logic               r_trig_r;
  logic [15:0]        r_dist_l;
  logic [15:0]        r_dist_r;
  logic               r_valid;
  logic               r_dist_ch;
  logic [TIMER_W-1:0] r_timer;   // shared by TRIG and GAP, never both
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_count;

  logic        w_level_l, w_rise_l, w_fall_l;
  logic        w_level_r, w_rise_r, w_fall_r;
  logic        w_level, w_rise, w_fall;
  logic        w_finish;
  logic [15:0] w_result;

  echo_sync u_sync_left (
    .clk     (clk_3125KHz),
    .reset   (reset),
    .i_echo  (echo_left),
    .o_level (w_level_l),
    .o_rise  (w_rise_l),
    .o_fall  (w_fall_l)
  );

  echo_sync u_sync_right (
    .clk     (clk_3125KHz),
    .reset   (reset),
    .i_echo  (echo_right),
    .o_level (w_level_r),
    .o_rise  (w_rise_r),
    .o_fall  (w_fall_r)
  );

  assign w_level = (r_ch == CH_RIGHT) ? w_level_r : w_level_l;
  assign w_rise  = (r_ch == CH_RIGHT) ? w_rise_r  : w_rise_l;
  assign w_fall  = (r_ch == CH_RIGHT) ? w_fall_r  : w_fall_l;

  // End-of-measurement decision. In MEASURE a falling edge takes priority
  // over a timeout landing on the same cycle, so a valid echo is never lost.
  // In WAIT_ECHO the timeout wins over a late rise so the measurement can
  // never outlive the timeout window.
  always_comb begin
    w_finish = 1'b0;
    w_result = TIMEOUT_DIST;
    if (r_state == WAIT_ECHO) begin
      w_finish = (r_tmo == '0);
    end else if (r_state == MEASURE) begin
      w_finish = w_fall || (r_tmo == '0);
      if (w_fall) begin
        w_result = scale_dist(r_count, SCALE_Q);
      end
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ch      <= CH_LEFT;
      r_trig_l  <= 1'b0;
      r_trig_r  <= 1'b0;
      r_dist_l  <= 16'd0;
      r_dist_r  <= 16'd0;
      r_valid   <= 1'b0;
      r_dist_ch <= CH_LEFT;
      r_timer   <= '0;
      r_tmo     <= '0;
      r_count   <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_trig_l <= (r_ch == CH_LEFT);
          r_trig_r <= (r_ch == CH_RIGHT);
          r_timer  <= TRIG_LOAD;
          r_state  <= TRIG;
        end

        TRIG: begin
          if (r_timer == '0) begin
            r_trig_l <= 1'b0;
            r_trig_r <= 1'b0;
            r_tmo    <= TMO_LOAD;
            r_state  <= WAIT_ECHO;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end

        WAIT_ECHO, MEASURE: begin
          if (w_finish) begin
            if (r_ch == CH_RIGHT) begin
              r_dist_r <= w_result;
            end else begin
              r_dist_l <= w_result;
            end
            r_valid   <= 1'b1;
            r_dist_ch <= r_ch;
            r_timer   <= GAP_LOAD;
            r_state   <= GAP;
          end else begin
            r_tmo <= r_tmo - TMO_W'(1);
            if (r_state == WAIT_ECHO) begin
              // The rise cycle itself is the first echo-high clock.
              if (w_rise) begin
                r_count <= CNT_W'(1);
                r_state <= MEASURE;
              end
            end else if (w_level && (r_count != '1)) begin
              r_count <= r_count + CNT_W'(1);
            end
          end
        end

        GAP: begin
          if (r_timer == '0) begin
            r_ch    <= ~r_ch;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer - TIMER_W'(1);
          end
        end

        default: begin
          r_trig_l <= 1'b0;
          r_trig_r <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign trig_left  = r_trig_l;
  assign trig_right = r_trig_r;
  assign dist_left  = r_dist_l;
  assign dist_right = r_dist_r;
  assign dist_valid = r_valid;
  assign dist_ch    = r_dist_ch;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger: directed bench for ultrasonic_ranger. The echo
// timeout is shortened so the whole run stays short; trigger width, gap
// and scale keep their default values.
module tb_ultrasonic_ranger;

  localparam int TRIG_CYC = 32;
  localparam int TMO_CYC  = 10500;
  localparam int GAP_CYC  = 6250;

  logic        clk_3125KHz = 1'b0;
  logic        reset       = 1'b1;
  logic        echo_left   = 1'b0;
  logic        echo_right  = 1'b0;
  logic        trig_left, trig_right, dist_valid, dist_ch;
  logic [15:0] dist_left, dist_right;

  int checks = 0;
  int passed = 0;
  bit both_hi = 1'b0;

  ultrasonic_ranger #(
    .TRIG_CYCLES    (TRIG_CYC),
    .TIMEOUT_CYCLES (TMO_CYC),
    .GAP_CYCLES     (GAP_CYC),
    .SCALE          (3597)
  ) dut (
    .clk_3125KHz (clk_3125KHz),
    .reset       (reset),
    .echo_left   (echo_left),
    .echo_right  (echo_right),
    .trig_left   (trig_left),
    .trig_right  (trig_right),
    .dist_left   (dist_left),
    .dist_right  (dist_right),
    .dist_valid  (dist_valid),
    .dist_ch     (dist_ch)
  );

  always #160 clk_3125KHz = ~clk_3125KHz;

  always @(negedge clk_3125KHz) begin
    if (trig_left && trig_right) both_hi = 1'b1;
  end

  // Waits (bounded) for the selected trigger to rise, then measures its
  // width. Returns on the first negedge where the trigger is low again,
  // i.e. the first WAIT_ECHO cycle.
  task automatic wait_trig(input bit ch, input int budget,
                           output int lead, output int width, output bit ok);
    ok = 1'b0; lead = 0; width = 0;
    while (lead < budget && !(ch ? trig_right : trig_left)) begin
      @(negedge clk_3125KHz); lead++;
    end
    if (ch ? trig_right : trig_left) begin
      while (width <= TRIG_CYC + 4 && (ch ? trig_right : trig_left)) begin
        @(negedge clk_3125KHz); width++;
      end
      ok = !(ch ? trig_right : trig_left);
    end
  endtask

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < budget && !ok) begin
      @(negedge clk_3125KHz); n++;
      ok = dist_valid;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; echo_left = 1'b0; echo_right = 1'b0;
    repeat (4) @(negedge clk_3125KHz);
    checks++; if ({trig_left, trig_right, dist_valid, dist_ch} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {trig_left, trig_right, dist_valid, dist_ch}); else passed++;
    checks++; if (dist_left !== 16'd0) $display("FAIL reset_dist_left: got %0d want 0", dist_left); else passed++;
    checks++; if (dist_right !== 16'd0) $display("FAIL reset_dist_right: got %0d want 0", dist_right); else passed++;
    reset = 1'b0;
  endtask

  // Left first: 10000-clock echo -> 548 mm; then right trigger after gap.
  task automatic test_left_far();
    int lead, width, n; bit ok;
    wait_trig(1'b0, 10, lead, width, ok);
    checks++; if (!ok || lead != 1 || width != TRIG_CYC) $display("FAIL left_trig1: ok=%0d lead=%0d width=%0d want 1/1/%0d", ok, lead, width, TRIG_CYC); else passed++;
    echo_left = 1'b1;
    repeat (10000) @(negedge clk_3125KHz);
    echo_left = 1'b0;
    wait_valid(20, n, ok);
    checks++; if (!ok || n != 3) $display("FAIL left_far_latency: ok=%0d n=%0d want 1/3", ok, n); else passed++;
    checks++; if (dist_left !== 16'd548) $display("FAIL left_far_dist: got %0d want 548", dist_left); else passed++;
    checks++; if (dist_ch !== 1'b0) $display("FAIL left_far_ch: got %0d want 0", dist_ch); else passed++;
    checks++; if (dist_right !== 16'd0) $display("FAIL left_far_right_hold: got %0d want 0", dist_right); else passed++;
    @(negedge clk_3125KHz);
    checks++; if (dist_valid !== 1'b0) $display("FAIL left_far_pulse_width: got %0d want 0", dist_valid); else passed++;
    // Right echo goes high during the gap and stays high through the trigger.
    echo_right = 1'b1;
    wait_trig(1'b1, GAP_CYC + 10, lead, width, ok);
    checks++; if (!ok || lead != GAP_CYC || width != TRIG_CYC) $display("FAIL right_trig1: ok=%0d lead=%0d width=%0d want 1/%0d/%0d", ok, lead, width, GAP_CYC, TRIG_CYC); else passed++;
  endtask

  // Echo already high on WAIT_ECHO entry must not start a measurement. It is
  // released partway so a wrongly started measurement would yield a distance.
  task automatic test_right_held_high();
    int n; bit ok;
    repeat (2000) @(negedge clk_3125KHz);
    echo_right = 1'b0;
    wait_valid(TMO_CYC, n, ok);
    checks++; if (!ok || n + 2000 != TMO_CYC) $display("FAIL held_timing: ok=%0d n=%0d want 1/%0d", ok, n + 2000, TMO_CYC); else passed++;
    checks++; if (dist_right !== 16'hFFFF) $display("FAIL held_dist: got %h want ffff", dist_right); else passed++;
    checks++; if (dist_ch !== 1'b1) $display("FAIL held_ch: got %0d want 1", dist_ch); else passed++;
    checks++; if (dist_left !== 16'd548) $display("FAIL held_left_hold: got %0d want 548", dist_left); else passed++;
    @(negedge clk_3125KHz);
  endtask

  // 1000-clock echo -> 54 mm, then echoes on both inputs during the gap.
  task automatic test_left_near_and_gap();
    int lead, width, n, pulses; bit ok;
    wait_trig(1'b0, GAP_CYC + 10, lead, width, ok);
    checks++; if (!ok || lead != GAP_CYC || width != TRIG_CYC) $display("FAIL left_trig2: ok=%0d lead=%0d width=%0d want 1/%0d/%0d", ok, lead, width, GAP_CYC, TRIG_CYC); else passed++;
    echo_left = 1'b1;
    repeat (1000) @(negedge clk_3125KHz);
    echo_left = 1'b0;
    wait_valid(20, n, ok);
    checks++; if (!ok || n != 3) $display("FAIL left_near_latency: ok=%0d n=%0d want 1/3", ok, n); else passed++;
    checks++; if (dist_left !== 16'd54) $display("FAIL left_near_dist: got %0d want 54", dist_left); else passed++;
    checks++; if (dist_ch !== 1'b0) $display("FAIL left_near_ch: got %0d want 0", dist_ch); else passed++;
    pulses = 0;
    repeat (100) @(negedge clk_3125KHz);
    echo_left = 1'b1; echo_right = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_3125KHz);
      if (i == 300) begin echo_left = 1'b0; echo_right = 1'b0; end
      if (dist_valid) pulses++;
    end
    checks++; if (pulses != 0) $display("FAIL gap_valid: got %0d pulses want 0", pulses); else passed++;
    checks++; if (dist_left !== 16'd54 || dist_right !== 16'hFFFF) $display("FAIL gap_hold: got %0d/%h want 54/ffff", dist_left, dist_right); else passed++;
  endtask

  task automatic test_right_timeout();
    int lead, width, n; bit ok;
    wait_trig(1'b1, GAP_CYC + 10, lead, width, ok);
    checks++; if (!ok || width != TRIG_CYC) $display("FAIL right_trig2: ok=%0d width=%0d want 1/%0d", ok, width, TRIG_CYC); else passed++;
    wait_valid(TMO_CYC + 10, n, ok);
    checks++; if (!ok || n != TMO_CYC) $display("FAIL timeout_timing: ok=%0d n=%0d want 1/%0d", ok, n, TMO_CYC); else passed++;
    checks++; if (dist_right !== 16'hFFFF || dist_ch !== 1'b1) $display("FAIL timeout_dist: got %h ch %0d want ffff ch 1", dist_right, dist_ch); else passed++;
    checks++; if (dist_left !== 16'd54) $display("FAIL timeout_left_hold: got %0d want 54", dist_left); else passed++;
    @(negedge clk_3125KHz);
    checks++; if (dist_valid !== 1'b0) $display("FAIL timeout_pulse_width: got %0d want 0", dist_valid); else passed++;
  endtask

  // Falling edge lands on the timeout cycle: count = TMO-3 = 10497 -> 576 mm.
  task automatic test_fall_timeout_tie();
    int lead, width, n; bit ok;
    wait_trig(1'b0, GAP_CYC + 10, lead, width, ok);
    checks++; if (!ok || lead != GAP_CYC) $display("FAIL left_trig3: ok=%0d lead=%0d want 1/%0d", ok, lead, GAP_CYC); else passed++;
    echo_left = 1'b1;
    repeat (TMO_CYC - 3) @(negedge clk_3125KHz);
    echo_left = 1'b0;
    wait_valid(20, n, ok);
    checks++; if (!ok || n != 3) $display("FAIL tie_latency: ok=%0d n=%0d want 1/3", ok, n); else passed++;
    checks++; if (dist_left !== 16'd576) $display("FAIL tie_dist: got %0d want 576", dist_left); else passed++;
  endtask

  task automatic test_reset_mid();
    int lead, width, pulses; bit ok;
    wait_trig(1'b1, GAP_CYC + 10, lead, width, ok);
    checks++; if (!ok) $display("FAIL right_trig3: ok=%0d want 1", ok); else passed++;
    echo_right = 1'b1;
    repeat (500) @(negedge clk_3125KHz);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_3125KHz);
      if (dist_valid) pulses++;
    end
    echo_right = 1'b0;
    checks++; if (pulses != 0) $display("FAIL abort_valid: got %0d pulses want 0", pulses); else passed++;
    checks++; if (dist_left !== 16'd0 || dist_right !== 16'd0 || dist_ch !== 1'b0) $display("FAIL abort_outputs: got %0d/%0d ch %0d want 0/0 ch 0", dist_left, dist_right, dist_ch); else passed++;
    reset = 1'b0;
    wait_trig(1'b0, 10, lead, width, ok);
    checks++; if (!ok || lead != 1 || width != TRIG_CYC) $display("FAIL abort_next_left: ok=%0d lead=%0d width=%0d want 1/1/%0d", ok, lead, width, TRIG_CYC); else passed++;
    // Reset during an active trigger drops it on the next edge.
    reset = 1'b1;
    repeat (2) @(negedge clk_3125KHz);
    reset = 1'b0;
    repeat (10) @(negedge clk_3125KHz);
    checks++; if (trig_left !== 1'b1) $display("FAIL trig_before_reset: got %0d want 1", trig_left); else passed++;
    reset = 1'b1;
    @(negedge clk_3125KHz);
    checks++; if (trig_left !== 1'b0 || trig_right !== 1'b0) $display("FAIL trig_drop: got %0d/%0d want 0/0", trig_left, trig_right); else passed++;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_left_far();
    test_right_held_high();
    test_left_near_and_gap();
    test_right_timeout();
    test_fall_timeout_tie();
    test_reset_mid();
    checks++; if (both_hi !== 1'b0) $display("FAIL both_triggers: got %0d want 0", both_hi); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
